ge_cell_monitor: RTL and testbench

Clocked response checker on the consuming side of the greater-or-equal cell interface. Samples an operand pair and the cell's single-bit result on a valid strobe, computes the expected unsigned `a >= b`, and counts both checks and mismatches. Captures the first mismatch and reports a sticky error flag. Sits beside the comparator in the flattened test designs, replacing ad-hoc waveform inspection with a synthesizable self-check.

---
 rtl/ge_mon_pkg.sv | 14 +
 rtl/ge_ref.sv | 13 +
 rtl/ge_cell_monitor.sv | 122 ++++++++++++
 tb/tb_ge_cell_monitor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ge_mon_pkg.sv
// Shared types and defaults for the greater-or-equal cell monitor.
package ge_mon_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    // Session state; the encoding is also visible on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mon_state_e;

endpackage

// File: rtl/ge_ref.sv
// Golden unsigned greater-or-equal comparator used as the reference.
module ge_ref #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             expected
);

    // Full-width unsigned compare, no sign interpretation.
    assign expected = (a >= b);

endmodule

// File: rtl/ge_cell_monitor.sv
// Response checker for a greater-or-equal cell: counts checked samples and
// mismatches, captures the first mismatch and holds a sticky error flag.
//
// Handshake: sample_valid qualifies a, b and ge_out for exactly the cycle it
// is high; there is no ready, every valid sample is consumed in RUN.
module ge_cell_monitor
    import ge_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ge_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b,
    output logic [CNT_W-1:0] first_idx,
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] check_q, check_d;
    logic [CNT_W-1:0] errc_q, errc_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] fa_q, fa_d;
    logic [WIDTH-1:0] fb_q, fb_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic             expected;
    logic             mismatch;

    ge_ref #(.WIDTH(WIDTH)) u_ref (
        .a        (a),
        .b        (b),
        .expected (expected)
    );

    assign mismatch = (ge_out != expected);

    // Next state, session clear, counting and first-mismatch capture.
    always_comb begin
        state_d = state_q;
        check_d = check_q;
        errc_d  = errc_q;
        err_d   = err_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        fidx_d  = fidx_q;

        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (!start && stop) state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            // start wins over stop and discards a coincident sample.
            check_d = '0;
            errc_d  = '0;
            err_d   = 1'b0;
            fa_d    = '0;
            fb_d    = '0;
            fidx_d  = '0;
        end else if (state_q == ST_RUN && sample_valid) begin
            if (check_q != CNT_MAX) check_d = check_q + CNT_ONE;
            if (mismatch) begin
                if (errc_q != CNT_MAX) errc_d = errc_q + CNT_ONE;
                if (!err_q) begin
                    fa_d   = a;
                    fb_d   = b;
                    fidx_d = check_q;
                    err_d  = 1'b1;
                end
            end
        end
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            check_q <= '0;
            errc_q  <= '0;
            err_q   <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            check_q <= check_d;
            errc_q  <= errc_d;
            err_q   <= err_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            fidx_q  <= fidx_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign check_cnt = check_q;
    assign err_cnt   = errc_q;
    assign first_a   = fa_q;
    assign first_b   = fb_q;
    assign first_idx = fidx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ge_cell_monitor.sv
// Bench for ge_cell_monitor: two instances (CNT_W=8 and CNT_W=3) share one
// stimulus stream and are compared every cycle against a session model.
module tb_ge_cell_monitor;

    logic       clk;
    logic       rst_n;
    logic       start, stop, sample_valid, ge_out;
    logic [3:0] a, b;

    logic       busy0, done0, err0;
    logic [7:0] cc0, ec0, fi0;
    logic [3:0] fa0, fb0;
    logic [1:0] st0;
    logic       busy1, done1, err1;
    logic [2:0] cc1, ec1, fi1;
    logic [3:0] fa1, fb1;
    logic [1:0] st1;

    int n_tests = 0;
    int n_fail  = 0;

    // model: state 0 idle, 1 run, 2 done
    int m_st;
    int m_cnt[2], m_ec[2], m_fa[2], m_fb[2], m_fi[2];
    int m_err[2];
    int m_max[2] = '{255, 7};

    ge_cell_monitor #(.WIDTH(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .sample_valid(sample_valid), .a(a), .b(b), .ge_out(ge_out),
        .busy(busy0), .done(done0), .err(err0), .check_cnt(cc0),
        .err_cnt(ec0), .first_a(fa0), .first_b(fb0), .first_idx(fi0),
        .dbg_state(st0)
    );

    ge_cell_monitor #(.WIDTH(4), .CNT_W(3)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .sample_valid(sample_valid), .a(a), .b(b), .ge_out(ge_out),
        .busy(busy1), .done(done1), .err(err1), .check_cnt(cc1),
        .err_cnt(ec1), .first_a(fa1), .first_b(fb1), .first_idx(fi1),
        .dbg_state(st1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural session model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0;
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_ec[i] = 0; m_err[i] = 0;
                m_fa[i] = 0; m_fb[i] = 0; m_fi[i] = 0;
            end
        end else if (start) begin
            m_st = 1;
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_ec[i] = 0; m_err[i] = 0;
                m_fa[i] = 0; m_fb[i] = 0; m_fi[i] = 0;
            end
        end else if (m_st == 1) begin
            if (sample_valid) begin
                for (int i = 0; i < 2; i++) begin
                    bit wrong;
                    wrong = (int'(ge_out) != ((int'(a) >= int'(b)) ? 1 : 0));
                    if (wrong && m_err[i] == 0) begin
                        m_fa[i] = a; m_fb[i] = b; m_fi[i] = m_cnt[i]; m_err[i] = 1;
                    end
                    if (wrong && m_ec[i] < m_max[i]) m_ec[i]++;
                    if (m_cnt[i] < m_max[i]) m_cnt[i]++;
                end
            end
            if (stop) m_st = 2;
        end
    end

    // per-cycle compare on the falling edge
    always @(negedge clk) begin
        chk("busy0", busy0, m_st == 1);
        chk("done0", done0, m_st == 2);
        chk("state0", st0, m_st);
        chk("err0", err0, m_err[0]);
        chk("check_cnt0", cc0, m_cnt[0]);
        chk("err_cnt0", ec0, m_ec[0]);
        chk("first_a0", fa0, m_fa[0]);
        chk("first_b0", fb0, m_fb[0]);
        chk("first_idx0", fi0, m_fi[0]);
        chk("busy1", busy1, m_st == 1);
        chk("done1", done1, m_st == 2);
        chk("err1", err1, m_err[1]);
        chk("check_cnt1", cc1, m_cnt[1]);
        chk("err_cnt1", ec1, m_ec[1]);
        chk("first_a1", fa1, m_fa[1]);
        chk("first_b1", fb1, m_fb[1]);
        chk("first_idx1", fi1, m_fi[1]);
    end

    // driver: apply one cycle of inputs, return just after the edge
    task automatic cyc(input logic st, input logic sp, input logic v,
                       input logic [3:0] aa, input logic [3:0] bb, input logic g);
        start = st; stop = sp; sample_valid = v; a = aa; b = bb; ge_out = g;
        @(posedge clk);
        #1;
        start = 0; stop = 0; sample_valid = 0;
    endtask

    task automatic run_pairs(input logic [4:0] flip);
        logic [3:0] pa[5] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd3};
        logic [3:0] pb[5] = '{4'd0, 4'd0, 4'd1, 4'd6, 4'd2};
        logic       pg[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, pa[i], pb[i], pg[i] ^ flip[i]);
        cyc(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        start = 0; stop = 0; sample_valid = 0; a = 0; b = 0; ge_out = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_cnt", cc0, 0);
        rst_n = 1;

        // sample in IDLE is ignored
        cyc(0, 0, 1, 4'd3, 4'd1, 1'b0);
        chk("idle_cnt", cc0, 0);
        chk("idle_err", err0, 0);

        // clean session
        run_pairs(5'b00000);
        chk("clean_cnt", cc0, 5);
        chk("clean_errcnt", ec0, 0);
        chk("clean_err", err0, 0);
        chk("clean_done", done0, 1);

        // injected mismatches at index 2 and 3
        run_pairs(5'b01100);
        chk("inj_errcnt", ec0, 2);
        chk("inj_err", err0, 1);
        chk("inj_first_a", fa0, 3);
        chk("inj_first_b", fb0, 1);
        chk("inj_first_idx", fi0, 2);

        // width boundary
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 4'd15, 4'd15, 1'b1);
        cyc(0, 0, 1, 4'd0, 4'd15, 1'b0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("bound_cnt", cc0, 2);
        chk("bound_errcnt", ec0, 0);

        // saturation: 10 wrong samples
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 4'd5, 4'd2, 1'b0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("sat_cnt", cc1, 7);
        chk("sat_errcnt", ec1, 7);
        chk("sat_first_idx", fi1, 0);
        chk("wide_cnt", cc0, 10);

        // stop together with a wrong sample
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 4'd1, 4'd2, 1'b1);
        chk("stopsamp_cnt", cc0, 1);
        chk("stopsamp_errcnt", ec0, 1);
        chk("stopsamp_done", done0, 1);
        // sample in DONE is ignored
        cyc(0, 0, 1, 4'd1, 4'd2, 1'b1);
        chk("done_hold_cnt", cc0, 1);
        // start and stop together in DONE
        cyc(1, 1, 0, 0, 0, 0);
        chk("startstop_busy", busy0, 1);
        chk("startstop_cnt", cc0, 0);
        chk("startstop_err", err0, 0);
        // start together with a sample in RUN
        cyc(0, 0, 1, 4'd7, 4'd1, 1'b1);
        cyc(1, 0, 1, 4'd1, 4'd7, 1'b1);
        chk("startsamp_cnt", cc0, 0);
        chk("startsamp_errcnt", ec0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] ra, rb;
            logic rg;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rg = (ra >= rb);
            if ($urandom_range(0, 9) == 0) rg = ~rg;
            cyc($urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 3) != 0, ra, rb, rg);
        end

        // reset mid-session with err_cnt = 3
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'd0, 4'd9, 1'b1);
        chk("pre_rst_errcnt", ec0, 3);
        rst_n = 0;
        #1;
        chk("async_busy", busy0, 0);
        chk("async_state", st0, 0);
        chk("async_err", err0, 0);
        chk("async_cnt", cc0, 0);
        chk("async_errcnt", ec0, 0);
        chk("async_fidx", fi0, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        cyc(0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
